// File: rtl/sync_stream_fifo.sv
// sync_stream_fifo: single-clock stream FIFO for DSP stage decoupling.
// Provides a fill level, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags with clear, and a synchronous flush.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// read mode; when undefined, data_out is a registered read with 1-cycle latency.
module sync_stream_fifo #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 16,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_L = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_L    = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_L    = (PTR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic [PTR_WIDTH:0]    mem_level;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_pop;

  // Extra pointer MSB makes DEPTH distinguishable from 0 after wrap.
  assign mem_level = wptr - rptr;

`ifdef SYNC_FIFO_FWFT_EN
  logic out_valid;
  logic load;

  // The output register counts as one storage slot, so total capacity stays DEPTH.
  assign level   = mem_level + {{PTR_WIDTH{1'b0}}, out_valid};
  assign empty   = !out_valid;
  assign rd_acc  = r_en && out_valid && !flush;
  assign load    = !flush && (mem_level != '0) && (!out_valid || rd_acc);
  assign mem_pop = load;

  // Output register refills from memory whenever it is vacant or being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_out  <= mem[rptr[PTR_WIDTH-1:0]];
    end else if (rd_acc) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign level   = mem_level;
  assign empty   = (mem_level == '0);
  assign rd_acc  = r_en && !empty && !flush;
  assign mem_pop = rd_acc;

  // Registered read: an accepted pop presents its word after the edge, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rptr[PTR_WIDTH-1:0]];
    end
  end
`endif

  // Flags come from registered pointer state only, never from this cycle's requests.
  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign wr_acc       = w_en && !full && !flush;

  // Storage array; not reset, only written by accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[PTR_WIDTH-1:0]] <= data_in;
    end
  end

  // Pointer update; flush wins over any same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (mem_pop) rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear, flush masks errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full && !flush) overflow <= 1'b1;
      else if (clr_err)           overflow <= 1'b0;
      if (r_en && empty && !flush) underflow <= 1'b1;
      else if (clr_err)            underflow <= 1'b0;
    end
  end

endmodule
